// File: rtl/typing_stats_bcd_if.sv
// Load/busy/done handshake and display-side bus for typing_stats_bcd.
// The master issues conversion requests; the slave returns BCD digits and enables.
interface typing_stats_bcd_if #(
    parameter int IN_W = 14
);
    logic [IN_W-1:0] value;
    logic            load;
    logic            busy;
    logic            done;
    logic            overflow;
    logic [3:0]      digit_one;
    logic [3:0]      digit_two;
    logic [3:0]      digit_three;
    logic [3:0]      digit_four;
    logic            one_en;
    logic            two_en;
    logic            three_en;
    logic            four_en;

    modport master (
        output value, load,
        input  busy, done, overflow,
        input  digit_one, digit_two, digit_three, digit_four,
        input  one_en, two_en, three_en, four_en
    );

    modport slave (
        input  value, load,
        output busy, done, overflow,
        output digit_one, digit_two, digit_three, digit_four,
        output one_en, two_en, three_en, four_en
    );
endinterface

// File: rtl/typing_stats_bcd.sv
// Sequential double-dabble binary-to-BCD converter for the typing statistics display.
// One shift per clock; display outputs only change when a conversion completes.
module typing_stats_bcd #(
    parameter int IN_W          = 14,
    parameter int MAX_VAL       = 9999,
    parameter bit BLANK_LEADING = 1'b1
) (
    input logic             fast_clk,
    input logic             rst,
    typing_stats_bcd_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam int              CNT_W  = $clog2(IN_W + 1);
    localparam logic [IN_W-1:0] MAX_V  = IN_W'(MAX_VAL);
    localparam logic [3:0]      EN_RST = BLANK_LEADING ? 4'b0001 : 4'b1111;

    state_t           state;
    state_t           state_nxt;
    logic [IN_W-1:0]  bin;
    logic [IN_W-1:0]  bin_nxt;
    logic [15:0]      bcd;
    logic [15:0]      bcd_adj;
    logic [15:0]      bcd_nxt;
    logic [CNT_W-1:0] cnt;
    logic             sat;
    logic             last;
    logic [3:0]       en_calc;
    logic [15:0]      digits;
    logic [3:0]       en;
    logic             ovf;

    assign last = (cnt == CNT_W'(1));

    // Add-3 correction on every nibble, then shift the joint {bcd,bin} register.
    always_comb begin
        bcd_adj = bcd;
        for (int i = 0; i < 4; i++) begin
            if (bcd[4*i +: 4] >= 4'd5) begin
                bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
            end
        end
        {bcd_nxt, bin_nxt} = {bcd_adj, bin} << 1;
    end

    always_comb begin
        en_calc = 4'b1111;
        if (BLANK_LEADING) begin
            en_calc[3] = |bcd_nxt[15:12];
            en_calc[2] = |bcd_nxt[15:8];
            en_calc[1] = |bcd_nxt[15:4];
            en_calc[0] = 1'b1;
        end
    end

    always_ff @(posedge fast_clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (bus.load) state_nxt = SHIFT;
            SHIFT:   if (last) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        bus.busy = (state != IDLE);
        bus.done = (state == DONE);
    end

    always_ff @(posedge fast_clk) begin
        if (rst) begin
            bin    <= '0;
            bcd    <= '0;
            cnt    <= '0;
            sat    <= 1'b0;
            digits <= '0;
            en     <= EN_RST;
            ovf    <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (bus.load) begin
                        bin <= (bus.value > MAX_V) ? MAX_V : bus.value;
                        sat <= (bus.value > MAX_V);
                        bcd <= '0;
                        cnt <= CNT_W'(IN_W);
                    end
                end
                SHIFT: begin
                    bcd <= bcd_nxt;
                    bin <= bin_nxt;
                    cnt <= cnt - CNT_W'(1);
                    if (last) begin
                        digits <= bcd_nxt;
                        en     <= en_calc;
                        ovf    <= sat;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.digit_one   = digits[15:12];
    assign bus.digit_two   = digits[11:8];
    assign bus.digit_three = digits[7:4];
    assign bus.digit_four  = digits[3:0];
    assign bus.one_en      = en[3];
    assign bus.two_en      = en[2];
    assign bus.three_en    = en[1];
    assign bus.four_en     = en[0];
    assign bus.overflow    = ovf;
endmodule

// File: tb/tb_typing_stats_bcd.sv
// Scoreboard bench for typing_stats_bcd: decimal reference model, queued
// expectations, and a monitor checking every cycle's outputs.
module tb_typing_stats_bcd;
    localparam int IN_W = 14;
    localparam int MAXV = 9999;

    typedef struct {
        logic [15:0] digits;
        logic [3:0]  en;
        logic        ovf;
        int          cyc;
    } exp_t;

    logic clk;
    logic rst;
    int   cyc;
    int   checks;
    int   errors;
    int   idle_from;
    bit   stim_done;
    exp_t exp_q[$];

    typing_stats_bcd_if #(.IN_W(IN_W)) bus ();

    typing_stats_bcd #(
        .IN_W(IN_W),
        .MAX_VAL(MAXV),
        .BLANK_LEADING(1'b1)
    ) dut (
        .fast_clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic exp_t model(input int v, input int t0);
        exp_t r;
        int   s;
        s = (v > MAXV) ? MAXV : v;
        r.digits = {4'(s / 1000), 4'((s / 100) % 10), 4'((s / 10) % 10), 4'(s % 10)};
        r.en     = {s >= 1000, s >= 100, s >= 10, 1'b1};
        r.ovf    = (v > MAXV);
        r.cyc    = t0 + IN_W;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Drive one cycle of inputs, then model whether the edge accepts the load.
    task automatic step(input logic l, input int v, input logic r);
        int e;
        bus.load  = l;
        bus.value = IN_W'(v);
        rst       = r;
        @(posedge clk);
        e = cyc;
        if (r) begin
            idle_from = e + 1;
        end else if (l && e >= idle_from) begin
            exp_q.push_back(model(v, e));
            idle_from = e + IN_W + 2;
        end
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, $urandom_range(0, 16383), 1'b0);
    endtask

    task automatic conv(input int v);
        step(1'b1, v, 1'b0);
        idle(IN_W + 1);
    endtask

    // Monitor: reset and done update the held display model; otherwise outputs must hold.
    initial begin
        exp_t held;
        exp_t got;
        logic rs;
        int   e;
        bit   started;
        started = 0;
        held = '{digits: 16'h0, en: 4'b0001, ovf: 1'b0, cyc: 0};
        forever begin
            @(posedge clk);
            rs = rst;
            e  = cyc;
            @(negedge clk);
            if (rs) begin
                started = 1;
                exp_q.delete();
                held = '{digits: 16'h0, en: 4'b0001, ovf: 1'b0, cyc: 0};
            end
            if (started) begin
                chk("busy", 32'(bus.busy), 32'(!rs && exp_q.size() != 0));
                if (!rs && bus.done === 1'b1) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_done", 32'(bus.done), 32'(0));
                    end else begin
                        held = exp_q.pop_front();
                        chk("done_cycle", 32'(e), 32'(held.cyc));
                    end
                end else begin
                    chk("done_low", 32'(bus.done), 32'(0));
                    if (exp_q.size() != 0 && exp_q[0].cyc <= e) begin
                        got = exp_q.pop_front();
                        chk("missing_done", 32'(0), 32'(got.cyc));
                    end
                end
                chk("digits", {bus.digit_one, bus.digit_two, bus.digit_three, bus.digit_four},
                    32'(held.digits));
                chk("enables", {bus.one_en, bus.two_en, bus.three_en, bus.four_en},
                    32'(held.en));
                chk("overflow", 32'(bus.overflow), 32'(held.ovf));
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        checks    = 0;
        errors    = 0;
        idle_from = 0;
        stim_done = 0;
        rst       = 1'b1;
        bus.load  = 1'b0;
        bus.value = '0;
        @(posedge clk);
        #1;
        step(1'b0, 0, 1'b1);
        step(1'b0, 0, 1'b1);
        idle(2);

        conv(1234);
        conv(7);
        conv(0);
        conv(305);
        conv(12000);
        conv(9999);
        conv(10000);

        step(1'b1, 1234, 1'b0);
        idle(4);
        step(1'b1, 42, 1'b0);
        idle(9);
        step(1'b1, 77, 1'b0);
        idle(2);

        step(1'b1, 500, 1'b0);
        idle(5);
        step(1'b0, 0, 1'b1);
        conv(88);
        conv(16383);

        for (int i = 0; i < 700; i++) begin
            n = $urandom_range(0, 199);
            if (n == 0) step(1'b0, 0, 1'b1);
            else step(($urandom_range(0, 2) == 0), $urandom_range(0, 16383), 1'b0);
        end

        bus.load = 1'b0;
        for (int i = 0; i < 40 && exp_q.size() != 0; i++) idle(1);
        idle(2);
        if (exp_q.size() != 0) begin
            chk("drain", 32'(exp_q.size()), 32'(0));
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
